// File: rtl/contador_pkg.sv
// Shared types and default parameter values for the per-channel word counter.
package contador_pkg;
   typedef enum logic {
      S_WAIT = 1'b0,
      S_RESP = 1'b1
   } estado_t;

   localparam int NCH_DEF         = 4;
   localparam int CNT_W_DEF       = 5;
   localparam int SAT_DEF         = 0;
   localparam int CLR_ON_READ_DEF = 0;
endpackage

// File: rtl/contador_canal.sv
// One counter channel: increments on inc, wraps or saturates at full scale,
// keeps a sticky overflow bit; a clear takes effect before the increment.
import contador_pkg::*;

module contador_canal #(
   parameter int CNT_W = CNT_W_DEF,
   parameter int SAT   = SAT_DEF
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cuenta,
   output logic             ovf
);
   logic [CNT_W-1:0] cuenta_reg, cuenta_next, base;
   logic             ovf_reg, ovf_next, base_ovf;

   always_comb begin
      base        = clr ? '0 : cuenta_reg;
      base_ovf    = clr ? 1'b0 : ovf_reg;
      cuenta_next = base;
      ovf_next    = base_ovf;
      if (inc) begin
         if (&base) begin
            ovf_next = 1'b1;
            if (SAT == 0) cuenta_next = '0;
         end else begin
            cuenta_next = base + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cuenta_reg <= '0;
         ovf_reg    <= 1'b0;
      end else begin
         cuenta_reg <= cuenta_next;
         ovf_reg    <= ovf_next;
      end
   end

   assign cuenta = cuenta_reg;
   assign ovf    = ovf_reg;
endmodule

// File: rtl/contador_canales.sv
// NCH independent word counters with a request/response read port that is
// only served while the system is idle; one response per request level.
import contador_pkg::*;

module contador_canales #(
   parameter int NCH         = NCH_DEF,
   parameter int CNT_W       = CNT_W_DEF,
   parameter int SAT         = SAT_DEF,
   parameter int CLR_ON_READ = CLR_ON_READ_DEF,
   parameter int IDX_W       = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [NCH-1:0]   valid_in,
   input  logic             idle,
   input  logic             req,
   input  logic [IDX_W-1:0] idx,
   output logic             valid_contador,
   output logic [CNT_W-1:0] contador_out,
   output logic             ovf_out,
   output logic             err_idx
);
   localparam logic [IDX_W:0] NCH_L = (IDX_W+1)'(NCH);

   estado_t          estado_reg;
   logic [CNT_W-1:0] cuenta_arr [NCH];
   logic [NCH-1:0]   ovf_vec;
   logic [NCH-1:0]   clr_vec;
   logic             accept;
   logic             idx_err;
   logic [CNT_W-1:0] sel_cuenta;
   logic             sel_ovf;

   assign accept  = (estado_reg == S_WAIT) && req && idle;
   assign idx_err = ({1'b0, idx} >= NCH_L);

   generate
      for (genvar gi = 0; gi < NCH; gi++) begin : g_canal
         // An out-of-range idx never matches, so a bad read clears nothing.
         assign clr_vec[gi] = (CLR_ON_READ != 0) && accept &&
                              ({1'b0, idx} == (IDX_W+1)'(gi));

         contador_canal #(
            .CNT_W (CNT_W),
            .SAT   (SAT)
         ) u_canal (
            .clk    (clk),
            .reset  (reset),
            .inc    (valid_in[gi]),
            .clr    (clr_vec[gi]),
            .cuenta (cuenta_arr[gi]),
            .ovf    (ovf_vec[gi])
         );
      end
   endgenerate

   always_comb begin
      sel_cuenta = '0;
      sel_ovf    = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if ({1'b0, idx} == (IDX_W+1)'(i)) begin
            sel_cuenta = cuenta_arr[i];
            sel_ovf    = ovf_vec[i];
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         estado_reg     <= S_WAIT;
         valid_contador <= 1'b0;
         contador_out   <= '0;
         ovf_out        <= 1'b0;
         err_idx        <= 1'b0;
      end else begin
         valid_contador <= 1'b0;
         case (estado_reg)
            S_WAIT: begin
               if (accept) begin
                  estado_reg     <= S_RESP;
                  valid_contador <= 1'b1;
                  contador_out   <= sel_cuenta;
                  ovf_out        <= sel_ovf;
                  err_idx        <= idx_err;
               end
            end
            S_RESP: begin
               // Held req must drop before another read can be accepted.
               if (!req) estado_reg <= S_WAIT;
            end
            default: estado_reg <= S_WAIT;
         endcase
      end
   end
endmodule

// File: tb/tb_contador_canales.sv
// Directed bench for contador_canales: three parameter variants share one
// stimulus stream and are checked every cycle against a behavioural model.
module tb_contador_canales;
   localparam int NCH   = 4;
   localparam int CNT_W = 5;
   localparam int IDX_W = 3;
   localparam int NDUT  = 3;
   localparam int MAXV  = (1 << CNT_W) - 1;

   logic             clk      = 1'b0;
   logic             reset    = 1'b0;
   logic             idle     = 1'b0;
   logic             req      = 1'b0;
   logic [NCH-1:0]   valid_in = '0;
   logic [IDX_W-1:0] idx      = '0;

   logic [NDUT-1:0]  vc, ov, er;
   logic [CNT_W-1:0] co [NDUT];

   int dsat [NDUT] = '{0, 1, 0};
   int dclr [NDUT] = '{0, 0, 1};

   int  m_cnt [NDUT][NCH];
   bit  m_ovf [NDUT][NCH];
   bit  m_busy;
   bit  e_valid;
   int  e_cnt [NDUT];
   bit  e_ovf [NDUT];
   bit  e_err;

   int checks = 0;
   int errors = 0;
   int nresp;

   always #5 clk = ~clk;

   contador_canales #(.NCH(NCH), .CNT_W(CNT_W), .SAT(0), .CLR_ON_READ(0), .IDX_W(IDX_W)) dut_a (
      .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
      .valid_contador(vc[0]), .contador_out(co[0]), .ovf_out(ov[0]), .err_idx(er[0]));

   contador_canales #(.NCH(NCH), .CNT_W(CNT_W), .SAT(1), .CLR_ON_READ(0), .IDX_W(IDX_W)) dut_b (
      .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
      .valid_contador(vc[1]), .contador_out(co[1]), .ovf_out(ov[1]), .err_idx(er[1]));

   contador_canales #(.NCH(NCH), .CNT_W(CNT_W), .SAT(0), .CLR_ON_READ(1), .IDX_W(IDX_W)) dut_c (
      .clk(clk), .reset(reset), .valid_in(valid_in), .idle(idle), .req(req), .idx(idx),
      .valid_contador(vc[2]), .contador_out(co[2]), .ovf_out(ov[2]), .err_idx(er[2]));

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_busy  = 1'b0;
      e_valid = 1'b0;
      e_err   = 1'b0;
      for (int k = 0; k < NDUT; k++) begin
         e_cnt[k] = 0;
         e_ovf[k] = 1'b0;
         for (int c = 0; c < NCH; c++) begin
            m_cnt[k][c] = 0;
            m_ovf[k][c] = 1'b0;
         end
      end
   endtask

   // What one clock edge must do, given the inputs held across it.
   task automatic model_step();
      bit acc, bad;
      int sel;
      if (!reset) begin
         model_reset();
         return;
      end
      acc = !m_busy && req && idle;
      sel = int'(idx);
      bad = (sel >= NCH);
      e_valid = acc;
      if (acc) begin
         e_err = bad;
         for (int k = 0; k < NDUT; k++) begin
            e_cnt[k] = bad ? 0 : m_cnt[k][sel];
            e_ovf[k] = bad ? 1'b0 : m_ovf[k][sel];
         end
         m_busy = 1'b1;
      end else if (!req) begin
         m_busy = 1'b0;
      end
      for (int k = 0; k < NDUT; k++) begin
         for (int c = 0; c < NCH; c++) begin
            if (acc && !bad && dclr[k] != 0 && c == sel) begin
               m_cnt[k][c] = 0;
               m_ovf[k][c] = 1'b0;
            end
            if (valid_in[c]) begin
               if (m_cnt[k][c] == MAXV) begin
                  m_ovf[k][c] = 1'b1;
                  m_cnt[k][c] = (dsat[k] != 0) ? MAXV : 0;
               end else begin
                  m_cnt[k][c] = m_cnt[k][c] + 1;
               end
            end
         end
      end
   endtask

   task automatic compare_all();
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("dut%0d valid_contador", k), int'(vc[k]), int'(e_valid));
         check($sformatf("dut%0d contador_out", k), int'(co[k]), e_cnt[k]);
         check($sformatf("dut%0d ovf_out", k), int'(ov[k]), int'(e_ovf[k]));
         check($sformatf("dut%0d err_idx", k), int'(er[k]), int'(e_err));
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   initial begin
      model_reset();
      #2;
      cycle();
      cycle();
      check("reset contador_out", int'(co[0]), 0);
      reset = 1'b1;

      // Two channels count three words each; channel 2 is read back.
      valid_in = 4'b0101;
      repeat (3) cycle();
      valid_in = '0;
      req = 1'b1; idx = 3'd2; idle = 1'b1;
      cycle();
      check("s1 valid", int'(vc[0]), 1);
      check("s1 count", int'(co[0]), 3);
      check("s1 ovf", int'(ov[0]), 0);
      req = 1'b0;
      cycle();

      // 33 words on channel 1: wrap gives 1, saturate gives 31.
      valid_in = 4'b0010;
      repeat (33) cycle();
      valid_in = '0;
      req = 1'b1; idx = 3'd1;
      cycle();
      check("s2 wrap count", int'(co[0]), 1);
      check("s2 wrap ovf", int'(ov[0]), 1);
      check("s2 sat count", int'(co[1]), 31);
      check("s2 sat ovf", int'(ov[1]), 1);
      req = 1'b0;
      cycle();

      // Requests outside idle are ignored; a held request answers once.
      idle = 1'b0; req = 1'b1; idx = 3'd0;
      repeat (5) begin
         cycle();
         check("s3 blocked", int'(vc[0]), 0);
      end
      idle = 1'b1;
      nresp = 0;
      repeat (4) begin
         cycle();
         nresp += int'(vc[0]);
      end
      check("s3 one response", nresp, 1);
      req = 1'b0;
      cycle();
      req = 1'b1;
      cycle();
      check("s3 rearm", int'(vc[0]), 1);
      req = 1'b0;
      cycle();

      // Clear-on-read racing an increment on the same channel.
      valid_in = 4'b0001;
      repeat (7) cycle();
      req = 1'b1; idx = 3'd0;
      cycle();
      check("s4 clr read", int'(co[2]), 7);
      req = 1'b0; valid_in = '0;
      cycle();
      req = 1'b1;
      cycle();
      check("s4 after clr", int'(co[2]), 1);
      check("s4 after clr ovf", int'(ov[2]), 0);
      req = 1'b0;
      cycle();

      // Out-of-range index, then every channel read back unchanged.
      req = 1'b1; idx = 3'd5;
      cycle();
      check("s5 err_idx", int'(er[0]), 1);
      check("s5 err count", int'(co[0]), 0);
      check("s5 err ovf", int'(ov[0]), 0);
      req = 1'b0;
      cycle();
      for (int ch = 0; ch < NCH; ch++) begin
         req = 1'b1; idx = IDX_W'(ch);
         cycle();
         if (ch == 0) check("s5 ch0 unchanged", int'(co[0]), 11);
         req = 1'b0;
         cycle();
      end

      // Asynchronous reset in the middle of a response cycle.
      req = 1'b1; idx = 3'd1;
      cycle();
      check("s6 in resp", int'(vc[0]), 1);
      #3;
      reset = 1'b0;
      #1;
      for (int k = 0; k < NDUT; k++) begin
         check($sformatf("s6 async dut%0d valid", k), int'(vc[k]), 0);
         check($sformatf("s6 async dut%0d count", k), int'(co[k]), 0);
         check($sformatf("s6 async dut%0d ovf", k), int'(ov[k]), 0);
         check($sformatf("s6 async dut%0d err", k), int'(er[k]), 0);
      end
      model_reset();
      req = 1'b0;
      cycle();
      #2;
      reset = 1'b1;
      valid_in = 4'b1111;
      cycle();
      valid_in = '0;
      req = 1'b1; idx = 3'd3;
      cycle();
      check("s6 post reset valid", int'(vc[0]), 1);
      check("s6 post reset count", int'(co[0]), 1);
      req = 1'b0;
      cycle();
      cycle();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
